multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Finite-state control sequencer for the multi-cycle variant of the RV32I datapath. It replaces the single-cycle decoder-plus-PCSrc glue: one instruction executes over 3–5+ cycles, and a single shared instruction/data memory with a ready handshake is reused across cycles. The block drives every datapath strobe and mux select, and it counts retired instructions. It sits beside the PC, IR, register file, ALU and memory, and owns no data path itself.

## Interface
- INSTRET_W, 32, width of the retired-instruction counter
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- opcode_i  in  7  IR[6:0]; valid from DECODE onward
- zero_i  in  1  ALU condition flag. ALU control resolves funct3, so 1 = branch condition true.
- mem_ready_i  in  1  shared memory completes the current access this cycle
- pc_write_o  out  1  load PC
- old_pc_write_o  out  1  latch current PC into OldPC
- ir_write_o  out  1  load IR from memory read data
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read_o / mem_write_o  out  1 each  memory request strobes
- reg_write_o  out  1  register file write enable
- wb_sel_o  out  2  write-back source: 00 ALUOut, 01 MDR, 10 PC (holds OldPC+4)
- alu_src_a_o  out  2  ALU A source: 00 PC, 01 rs1 (A register), 10 OldPC
- alu_src_b_o  out  2  ALU B source: 00 rs2 (B register), 01 constant 4, 10 immediate
- alu_op_o  out  2  ALU operation: 00 add, 01 branch compare, 10 funct-decoded
- pc_src_o  out  1  PC source: 0 = live ALU result, 1 = ALUOut
- halt_o  out  1  illegal opcode trapped
- instret_o  out  INSTRET_W  retired-instruction count
- state_o  out  4  current state encoding, for debug

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, HALT.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, a=00, b=01, op=00.
  - Stays in FETCH while mem_ready_i=0.
  - In the ready cycle: ir_write=1, pc_write=1, old_pc_write=1, pc_src=0; next state DECODE.
- DECODE: a=10, b=10, op=00, so ALUOut ← OldPC+imm (branch/JAL target). Dispatch on opcode_i:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - anything else → HALT
- EXEC_R: a=01, b=00, op=10 → WB_ALU.
- EXEC_I: a=01, b=10, op=10 → WB_ALU.
- MEM_ADDR: a=01, b=10, op=00 → MEM_RD for loads, MEM_WR for stores.
- MEM_RD: iord=1, mem_read=1 held until mem_ready_i=1 → WB_MEM.
- MEM_WR: iord=1, mem_write=1 held until mem_ready_i=1 → FETCH (retire).
- WB_ALU: reg_write=1, wb=00 → FETCH (retire).
- WB_MEM: reg_write=1, wb=01 → FETCH (retire).
- BRANCH: a=01, b=00, op=01. If zero_i=1: pc_write=1, pc_src=1. → FETCH (retire).
- JAL: reg_write=1, wb=10, pc_write=1, pc_src=1 → FETCH (retire).
- JALR: a=01, b=10, op=00, reg_write=1, wb=10, pc_write=1, pc_src=0 → FETCH (retire).
  - The rd write uses the pre-edge PC value, so rd=rs1 is safe.
- HALT: halt_o=1, all strobes 0. Held until rst_i.
- instret_o increments by 1 on each retire transition and wraps modulo 2^INSTRET_W.

## Timing
- Reset (rst_i=1 at an edge): state ← FETCH, instret ← 0, halt_o=0.
  - All strobes are forced 0 combinationally while rst_i=1.
  - First request (mem_read=1) appears in the first cycle after rst_i falls.
- Reset mid-instruction, including mid memory wait: abandons the instruction; no write strobes and no count.
- Strobes are Moore outputs except the ready-qualified FETCH strobes and the zero_i-qualified BRANCH pc_write, which are same-cycle combinational.
- mem_ready_i is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere.
  - Ready in the same cycle as the request means zero wait.
- Cycle counts with zero-wait memory:
  - R/I-type: 4
  - load: 5
  - store: 4
  - branch, JAL, JALR: 3
- Each wait cycle adds 1 to the instruction's cycle count.

## Test plan
- Reset then R-type (opcode 0110011), ready tied 1:
  - states FETCH→DECODE→EXEC_R→WB_ALU→FETCH
  - reg_write pulses exactly in cycle 4
  - instret_o = 1 after the 4th edge
- Load with 3 wait cycles on MEM_RD:
  - mem_read_o and iord_o=1 held 4 cycles
  - WB_MEM with wb_sel_o=01 follows
  - total 8 cycles
- Branch with zero_i=0 vs 1:
  - zero_i=0: pc_write_o stays 0 in BRANCH
  - zero_i=1: pc_write_o=1 with pc_src_o=1
  - both retire in 3 cycles
- JAL and JALR: reg_write_o=1, pc_write_o=1 and wb_sel_o=10 in the same cycle; pc_src_o=1 for JAL, 0 for JALR.
- Opcode 0000000: DECODE→HALT, halt_o=1 for 20+ cycles with all strobes 0; rst_i pulse → FETCH, halt_o=0.
- rst_i asserted during a MEM_WR wait: mem_write_o drops the same cycle, instret unchanged; preload instret near wrap (INSTRET_W=4, 15 retires) → wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// master = sequencer side (drives strobes), slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           opcode_i;
    logic                 zero_i;
    logic                 mem_ready_i;
    logic                 pc_write_o;
    logic                 old_pc_write_o;
    logic                 ir_write_o;
    logic                 iord_o;
    logic                 mem_read_o;
    logic                 mem_write_o;
    logic                 reg_write_o;
    logic [1:0]           wb_sel_o;
    logic [1:0]           alu_src_a_o;
    logic [1:0]           alu_src_b_o;
    logic [1:0]           alu_op_o;
    logic                 pc_src_o;
    logic                 halt_o;
    logic [INSTRET_W-1:0] instret_o;
    logic [3:0]           state_o;

    modport master (
        input  opcode_i, zero_i, mem_ready_i,
        output pc_write_o, old_pc_write_o, ir_write_o, iord_o, mem_read_o,
               mem_write_o, reg_write_o, wb_sel_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, pc_src_o, halt_o, instret_o, state_o
    );

    modport slave (
        output opcode_i, zero_i, mem_ready_i,
        input  pc_write_o, old_pc_write_o, ir_write_o, iord_o, mem_read_o,
               mem_write_o, reg_write_o, wb_sel_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, pc_src_o, halt_o, instret_o, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: drives datapath strobes/selects per
// state, waits on the shared memory ready, and counts retired instructions.
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       old_pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_src;
        logic       halt;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = ctrl_t'(17'd0);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t               state_r;
    state_t               next_state_s;
    ctrl_t                ctrl_raw_s;
    ctrl_t                ctrl_s;
    logic                 retire_s;
    logic [INSTRET_W-1:0] instret_r;

    // State register and retired-instruction counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= S_FETCH;
            instret_r <= {INSTRET_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (retire_s) begin
                instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        next_state_s = state_r;
        ctrl_raw_s   = CTRL_IDLE;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                ctrl_raw_s.mem_read  = 1'b1;
                ctrl_raw_s.alu_src_b = 2'b01;
                if (bus.mem_ready_i) begin
                    ctrl_raw_s.ir_write     = 1'b1;
                    ctrl_raw_s.pc_write     = 1'b1;
                    ctrl_raw_s.old_pc_write = 1'b1;
                    next_state_s            = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute OldPC+imm into ALUOut for branch/JAL targets.
                ctrl_raw_s.alu_src_a = 2'b10;
                ctrl_raw_s.alu_src_b = 2'b10;
                case (bus.opcode_i)
                    OP_R:          next_state_s = S_EXEC_R;
                    OP_I:          next_state_s = S_EXEC_I;
                    OP_LD, OP_ST:  next_state_s = S_MEM_ADDR;
                    OP_BR:         next_state_s = S_BRANCH;
                    OP_JAL:        next_state_s = S_JAL;
                    OP_JALR:       next_state_s = S_JALR;
                    default:       next_state_s = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                ctrl_raw_s.alu_src_a = 2'b01;
                ctrl_raw_s.alu_op    = 2'b10;
                next_state_s         = S_WB_ALU;
            end
            S_EXEC_I: begin
                ctrl_raw_s.alu_src_a = 2'b01;
                ctrl_raw_s.alu_src_b = 2'b10;
                ctrl_raw_s.alu_op    = 2'b10;
                next_state_s         = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                ctrl_raw_s.alu_src_a = 2'b01;
                ctrl_raw_s.alu_src_b = 2'b10;
                if (bus.opcode_i == OP_ST) begin
                    next_state_s = S_MEM_WR;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                ctrl_raw_s.iord     = 1'b1;
                ctrl_raw_s.mem_read = 1'b1;
                if (bus.mem_ready_i) begin
                    next_state_s = S_WB_MEM;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                ctrl_raw_s.iord      = 1'b1;
                ctrl_raw_s.mem_write = 1'b1;
                if (bus.mem_ready_i) begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_WB_ALU: begin
                ctrl_raw_s.reg_write = 1'b1;
                next_state_s         = S_FETCH;
                retire_s             = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_raw_s.reg_write = 1'b1;
                ctrl_raw_s.wb_sel    = 2'b01;
                next_state_s         = S_FETCH;
                retire_s             = 1'b1;
            end
            S_BRANCH: begin
                ctrl_raw_s.alu_src_a = 2'b01;
                ctrl_raw_s.alu_op    = 2'b01;
                ctrl_raw_s.pc_write  = bus.zero_i;
                ctrl_raw_s.pc_src    = bus.zero_i;
                next_state_s         = S_FETCH;
                retire_s             = 1'b1;
            end
            S_JAL: begin
                ctrl_raw_s.reg_write = 1'b1;
                ctrl_raw_s.wb_sel    = 2'b10;
                ctrl_raw_s.pc_write  = 1'b1;
                ctrl_raw_s.pc_src    = 1'b1;
                next_state_s         = S_FETCH;
                retire_s             = 1'b1;
            end
            S_JALR: begin
                // rd takes the pre-edge PC, so rd == rs1 is safe.
                ctrl_raw_s.alu_src_a = 2'b01;
                ctrl_raw_s.alu_src_b = 2'b10;
                ctrl_raw_s.reg_write = 1'b1;
                ctrl_raw_s.wb_sel    = 2'b10;
                ctrl_raw_s.pc_write  = 1'b1;
                next_state_s         = S_FETCH;
                retire_s             = 1'b1;
            end
            S_HALT: begin
                ctrl_raw_s.halt = 1'b1;
                next_state_s    = S_HALT;
            end
            default: begin
                next_state_s = S_HALT;
            end
        endcase
    end

    // Reset silences every output in the same cycle it is asserted.
    always_comb begin
        if (rst_i) begin
            ctrl_s = CTRL_IDLE;
        end else begin
            ctrl_s = ctrl_raw_s;
        end
    end

    assign bus.pc_write_o     = ctrl_s.pc_write;
    assign bus.old_pc_write_o = ctrl_s.old_pc_write;
    assign bus.ir_write_o     = ctrl_s.ir_write;
    assign bus.iord_o         = ctrl_s.iord;
    assign bus.mem_read_o     = ctrl_s.mem_read;
    assign bus.mem_write_o    = ctrl_s.mem_write;
    assign bus.reg_write_o    = ctrl_s.reg_write;
    assign bus.wb_sel_o       = ctrl_s.wb_sel;
    assign bus.alu_src_a_o    = ctrl_s.alu_src_a;
    assign bus.alu_src_b_o    = ctrl_s.alu_src_b;
    assign bus.alu_op_o       = ctrl_s.alu_op;
    assign bus.pc_src_o       = ctrl_s.pc_src;
    assign bus.halt_o         = ctrl_s.halt;
    assign bus.instret_o      = instret_r;
    assign bus.state_o        = state_r;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: each instruction class is expanded into its expected
// per-cycle output script and compared against the sequencer every cycle.
module tb_multicycle_ctrl;
    localparam int IW = 4;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7, S_WB_MEM = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10,
        S_JALR = 4'd11, S_HALT = 4'd12;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
        OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_BR = 7'b1100011,
        OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    typedef struct packed {
        logic       pc_write;
        logic       old_pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       pc_src;
        logic       halt;
        logic [3:0] st;
        logic [IW-1:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [1:0] kind;   // 0 instret, 1 halt, 2 state
        logic [3:0] val;
    } lit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.INSTRET_W(IW)) bus ();
    multicycle_ctrl #(.INSTRET_W(IW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    exp_t expq[$];
    lit_t litq[$];
    int total = 0;
    int bad = 0;
    logic [IW-1:0] m_cnt;
    logic [6:0] legal[7] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t: got %b want %b", nm, $time, act, req);
        end
    endtask

    // Single compare process: every cycle's scripted expectation, then literal pins.
    always @(negedge clk) begin : cmp
        exp_t e;
        lit_t l;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("ctrl", {bus.pc_write_o, bus.old_pc_write_o, bus.ir_write_o,
                         bus.iord_o, bus.mem_read_o, bus.mem_write_o,
                         bus.reg_write_o, bus.wb_sel_o, bus.alu_src_a_o,
                         bus.alu_src_b_o, bus.alu_op_o, bus.pc_src_o, bus.halt_o},
                {e.pc_write, e.old_pc_write, e.ir_write, e.iord, e.mem_read,
                 e.mem_write, e.reg_write, e.wb, e.a, e.b, e.op, e.pc_src, e.halt});
            chk("state", {13'd0, bus.state_o}, {13'd0, e.st});
            chk("instret", {13'd0, bus.instret_o}, {13'd0, e.cnt});
        end
        while (litq.size() != 0) begin
            l = litq.pop_front();
            case (l.kind)
                2'd0:    chk("lit_instret", {13'd0, bus.instret_o}, {13'd0, l.val});
                2'd1:    chk("lit_halt", {16'd0, bus.halt_o}, {13'd0, l.val});
                default: chk("lit_state", {13'd0, bus.state_o}, {13'd0, l.val});
            endcase
        end
    end

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic lit(input logic [1:0] k, input logic [3:0] v);
        lit_t l;
        l.kind = k;
        l.val  = v;
        litq.push_back(l);
    endtask

    // One clock: drive inputs, queue the expectation, advance the model counter.
    task automatic step(input logic r, input logic rdy, input logic z,
                        input logic [6:0] opc, input exp_t e_in, input bit ret);
        exp_t e = e_in;
        rst = r;
        bus.mem_ready_i = rdy;
        bus.zero_i = z;
        bus.opcode_i = opc;
        e.cnt = m_cnt;
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (r) m_cnt = '0;
        else if (ret) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw,
                             input logic z, input int abort);
        exp_t e;
        for (int i = 0; i < fw; i++) begin
            e = blank(S_FETCH); e.mem_read = 1'b1; e.b = 2'b01;
            step(1'b0, 1'b0, rbit(), 7'($urandom), e, 1'b0);
        end
        e = blank(S_FETCH); e.mem_read = 1'b1; e.b = 2'b01;
        e.ir_write = 1'b1; e.pc_write = 1'b1; e.old_pc_write = 1'b1;
        step(1'b0, 1'b1, rbit(), 7'($urandom), e, 1'b0);
        e = blank(S_DECODE); e.a = 2'b10; e.b = 2'b10;
        step(1'b0, rbit(), rbit(), opc, e, 1'b0);
        case (opc)
            OP_R, OP_I: begin
                e = blank(opc == OP_R ? S_EXEC_R : S_EXEC_I);
                e.a = 2'b01; e.op = 2'b10; e.b = (opc == OP_R) ? 2'b00 : 2'b10;
                step(1'b0, rbit(), rbit(), opc, e, 1'b0);
                e = blank(S_WB_ALU); e.reg_write = 1'b1;
                step(1'b0, rbit(), rbit(), opc, e, 1'b1);
            end
            OP_LD, OP_ST: begin
                e = blank(S_MEM_ADDR); e.a = 2'b01; e.b = 2'b10;
                step(1'b0, rbit(), rbit(), opc, e, 1'b0);
                for (int i = 0; i <= mw; i++) begin
                    e = blank(opc == OP_LD ? S_MEM_RD : S_MEM_WR);
                    e.iord = 1'b1;
                    if (opc == OP_LD) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                    if (i == abort) begin
                        step(1'b1, 1'b1, rbit(), opc, blank(e.st), 1'b0);
                        return;
                    end
                    step(1'b0, (i == mw), rbit(), opc, e, (opc == OP_ST) && (i == mw));
                end
                if (opc == OP_LD) begin
                    e = blank(S_WB_MEM); e.reg_write = 1'b1; e.wb = 2'b01;
                    step(1'b0, rbit(), rbit(), opc, e, 1'b1);
                end
            end
            OP_BR: begin
                e = blank(S_BRANCH); e.a = 2'b01; e.op = 2'b01;
                e.pc_write = z; e.pc_src = z;
                step(1'b0, rbit(), z, opc, e, 1'b1);
            end
            OP_JAL: begin
                e = blank(S_JAL); e.reg_write = 1'b1; e.wb = 2'b10;
                e.pc_write = 1'b1; e.pc_src = 1'b1;
                step(1'b0, rbit(), rbit(), opc, e, 1'b1);
            end
            OP_JALR: begin
                e = blank(S_JALR); e.a = 2'b01; e.b = 2'b10; e.reg_write = 1'b1;
                e.wb = 2'b10; e.pc_write = 1'b1;
                step(1'b0, rbit(), rbit(), opc, e, 1'b1);
            end
            default: begin
                for (int i = 0; i < 22; i++) begin
                    e = blank(S_HALT); e.halt = 1'b1;
                    step(1'b0, rbit(), rbit(), opc, e, 1'b0);
                end
                step(1'b1, rbit(), rbit(), opc, blank(S_HALT), 1'b0);
                lit(2'd1, 4'd0);
                lit(2'd2, S_FETCH);
            end
        endcase
    endtask

    initial begin
        logic [6:0] opc;
        int mw;
        int ab;
        rst = 1'b1;
        bus.mem_ready_i = 1'b0;
        bus.zero_i = 1'b0;
        bus.opcode_i = 7'd0;
        m_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 7'd0, blank(S_FETCH), 1'b0);

        run_instr(OP_R, 0, 0, 1'b0, -1);
        lit(2'd0, 4'd1);
        run_instr(OP_LD, 0, 3, 1'b0, -1);
        lit(2'd0, 4'd2);
        run_instr(OP_BR, 0, 0, 1'b0, -1);
        run_instr(OP_BR, 1, 0, 1'b1, -1);
        run_instr(OP_JAL, 0, 0, 1'b0, -1);
        run_instr(OP_JALR, 2, 0, 1'b0, -1);
        lit(2'd0, 4'd6);
        run_instr(OP_ST, 0, 3, 1'b0, 1);
        lit(2'd0, 4'd0);
        run_instr(7'b0000000, 0, 0, 1'b0, -1);

        for (int i = 0; i < 15; i++)
            run_instr(legal[$urandom_range(6, 0)], $urandom_range(2, 0),
                      $urandom_range(2, 0), rbit(), -1);
        lit(2'd0, 4'd15);
        run_instr(OP_I, 0, 0, 1'b0, -1);
        lit(2'd0, 4'd0);

        for (int i = 0; i < 60; i++) begin
            opc = ($urandom_range(15, 0) == 0) ? 7'b1111111 : legal[$urandom_range(6, 0)];
            mw = $urandom_range(3, 0);
            ab = (opc == OP_ST && mw > 0 && $urandom_range(3, 0) == 0) ?
                 $urandom_range(mw - 1, 0) : -1;
            run_instr(opc, $urandom_range(2, 0), mw, rbit(), ab);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
